// File: rtl/atm_pkg.sv
// Shared state and menu-mode encodings for the multi-account ATM controller.
package atm_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    PIN      = 4'd1,
    MENU     = 4'd2,
    PREVIEW  = 4'd3,
    SHOW_BAL = 4'd4,
    RAPID    = 4'd5,
    WITHDRAW = 4'd6,
    DEPOSIT  = 4'd7,
    EXIT     = 4'd8
  } atm_state_e;

  localparam logic [2:0] MODE_BAL      = 3'd1;
  localparam logic [2:0] MODE_RAPID    = 3'd2;
  localparam logic [2:0] MODE_WITHDRAW = 3'd3;
  localparam logic [2:0] MODE_DEPOSIT  = 3'd4;
  localparam logic [2:0] MODE_EXIT     = 3'd5;

  function automatic logic mode_valid(input logic [2:0] m);
    return (m >= MODE_BAL) && (m <= MODE_EXIT);
  endfunction

  // States where the inactivity timeout is allowed to end the session.
  function automatic logic timed_state(input atm_state_e s);
    return (s == PIN) || (s == MENU) || (s == WITHDRAW) || (s == DEPOSIT);
  endfunction

  // States where a verified customer is present and the balance is shown.
  function automatic logic session_state(input atm_state_e s);
    return (s == MENU) || (s == PREVIEW) || (s == SHOW_BAL) || (s == RAPID) ||
           (s == WITHDRAW) || (s == DEPOSIT);
  endfunction

endpackage

// File: rtl/atm_ctrl_multi_timer.sv
// Loadable up-counter with synchronous clear and terminal-count compare.
module atm_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign done = (cnt == term);

endmodule

// File: rtl/atm_ctrl_multi.sv
// Multi-account ATM session controller: PIN/lockout, menu, timed preview and
// balance transactions. All outputs and account state are registered.
module atm_ctrl_multi
  import atm_pkg::*;
#(
  parameter int               NUM_ACCTS   = 4,
  parameter int               BAL_W       = 16,
  parameter int               AMT_W       = 8,
  parameter int               PIN_W       = 4,
  parameter logic [PIN_W-1:0] PIN_BASE    = 4'hA,
  parameter int               MAX_TRIES   = 3,
  parameter int               INIT_BAL    = 100,
  parameter int               RAPID_AMT   = 20,
  parameter int               PREVIEW_CYC = 5_000_000,
  parameter int               TIMEOUT_CYC = 250_000_000,
  localparam int              ACCT_W      = $clog2(NUM_ACCTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 card_present,
  input  logic [ACCT_W-1:0]    card_id,
  input  logic [PIN_W-1:0]     pin_in,
  input  logic [2:0]           menu_sel,
  input  logic                 confirm,
  input  logic                 cancel,
  input  logic [AMT_W-1:0]     amount,
  output logic [BAL_W-1:0]     balance_out,
  output logic [3:0]           state_out,
  output logic [2:0]           mode_out,
  output logic                 ok_pulse,
  output logic                 fail_pulse,
  output logic                 beep,
  output logic [NUM_ACCTS-1:0] locked
);

  localparam int               TRY_W     = $clog2(MAX_TRIES + 1);
  localparam int               PV_W      = $clog2(PREVIEW_CYC + 1);
  localparam int               TO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BAL_W-1:0] BAL_RST   = BAL_W'(INIT_BAL);
  localparam logic [BAL_W-1:0] RAPID_BAL = BAL_W'(RAPID_AMT);

  atm_state_e        state, nxt;
  logic [ACCT_W-1:0] acct;
  logic [BAL_W-1:0]  bal_q   [NUM_ACCTS];
  logic [TRY_W-1:0]  tries_q [NUM_ACCTS];
  logic [2:0]        menu_q;

  logic [BAL_W-1:0]  cur_bal, amt_ext, wr_data;
  logic [BAL_W:0]    dep_sum;
  logic [TRY_W-1:0]  tries_cur;
  logic              wr_en, tries_inc, tries_clr, lock_set, acct_ld, mode_ld;
  logic              ok_n, fail_n;
  logic              pv_done, to_done, to_clr;
  logic              pin_ok, wd_bad, dep_bad, rapid_bad, last_try;

  assign cur_bal   = bal_q[acct];
  assign tries_cur = tries_q[acct];
  assign amt_ext   = BAL_W'(amount);
  // One extra bit so a deposit overflow is visible as the carry.
  assign dep_sum   = {1'b0, cur_bal} + {1'b0, amt_ext};
  assign pin_ok    = (pin_in == (PIN_BASE ^ PIN_W'(acct)));
  assign wd_bad    = (amount == '0) || (amt_ext > cur_bal);
  assign dep_bad   = (amount == '0) || dep_sum[BAL_W];
  assign rapid_bad = (RAPID_BAL > cur_bal);
  assign last_try  = (32'(tries_cur) + 1 >= MAX_TRIES);

  atm_timer #(.W(PV_W)) u_preview (
    .clk      (clk),
    .rst      (rst),
    .clr      (state != PREVIEW),
    .en       (state == PREVIEW),
    .load     (1'b0),
    .load_val ('0),
    .term     (PV_W'(PREVIEW_CYC - 1)),
    .done     (pv_done)
  );

  // Any user action or state transition restarts the inactivity window.
  assign to_clr = confirm | cancel | (menu_sel != menu_q) | (nxt != state);

  atm_timer #(.W(TO_W)) u_idle (
    .clk      (clk),
    .rst      (rst),
    .clr      (to_clr),
    .en       (timed_state(state)),
    .load     (1'b0),
    .load_val ('0),
    .term     (TO_W'(TIMEOUT_CYC - 1)),
    .done     (to_done)
  );

  always_comb begin
    nxt       = state;
    ok_n      = 1'b0;
    fail_n    = 1'b0;
    wr_en     = 1'b0;
    wr_data   = cur_bal;
    tries_inc = 1'b0;
    tries_clr = 1'b0;
    lock_set  = 1'b0;
    acct_ld   = 1'b0;
    mode_ld   = 1'b0;
    case (state)
      IDLE: if (card_present) begin
        acct_ld = 1'b1;
        if (locked[card_id]) begin
          fail_n = 1'b1;
          nxt    = EXIT;
        end else begin
          nxt = PIN;
        end
      end
      EXIT: if (!card_present) nxt = IDLE;
      default: if (!card_present) begin
        nxt = EXIT;
      end else begin
        case (state)
          PIN: if (cancel) begin
            nxt = EXIT;
          end else if (confirm) begin
            if (pin_ok) begin
              ok_n      = 1'b1;
              tries_clr = 1'b1;
              nxt       = MENU;
            end else begin
              fail_n    = 1'b1;
              tries_inc = 1'b1;
              if (last_try) begin
                lock_set = 1'b1;
                nxt      = EXIT;
              end
            end
          end else if (to_done) begin
            fail_n = 1'b1;
            nxt    = EXIT;
          end
          MENU: if (cancel) begin
            nxt = EXIT;
          end else if (mode_valid(menu_sel)) begin
            mode_ld = 1'b1;
            nxt     = PREVIEW;
          end else if (to_done) begin
            fail_n = 1'b1;
            nxt    = EXIT;
          end
          PREVIEW: if (pv_done) begin
            case (mode_out)
              MODE_BAL:      nxt = SHOW_BAL;
              MODE_RAPID:    nxt = RAPID;
              MODE_WITHDRAW: nxt = WITHDRAW;
              MODE_DEPOSIT:  nxt = DEPOSIT;
              default:       nxt = EXIT;
            endcase
          end
          SHOW_BAL: begin
            ok_n = 1'b1;
            nxt  = MENU;
          end
          RAPID: begin
            nxt = MENU;
            if (rapid_bad) begin
              fail_n = 1'b1;
            end else begin
              ok_n    = 1'b1;
              wr_en   = 1'b1;
              wr_data = cur_bal - RAPID_BAL;
            end
          end
          WITHDRAW: if (cancel) begin
            nxt = MENU;
          end else if (confirm) begin
            nxt = MENU;
            if (wd_bad) begin
              fail_n = 1'b1;
            end else begin
              ok_n    = 1'b1;
              wr_en   = 1'b1;
              wr_data = cur_bal - amt_ext;
            end
          end else if (to_done) begin
            fail_n = 1'b1;
            nxt    = EXIT;
          end
          DEPOSIT: if (cancel) begin
            nxt = MENU;
          end else if (confirm) begin
            nxt = MENU;
            if (dep_bad) begin
              fail_n = 1'b1;
            end else begin
              ok_n    = 1'b1;
              wr_en   = 1'b1;
              wr_data = dep_sum[BAL_W-1:0];
            end
          end else if (to_done) begin
            fail_n = 1'b1;
            nxt    = EXIT;
          end
          default: nxt = IDLE;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acct        <= '0;
      menu_q      <= '0;
      mode_out    <= '0;
      ok_pulse    <= 1'b0;
      fail_pulse  <= 1'b0;
      beep        <= 1'b0;
      balance_out <= '0;
    end else begin
      state      <= nxt;
      menu_q     <= menu_sel;
      ok_pulse   <= ok_n;
      fail_pulse <= fail_n;
      beep       <= ok_n | fail_n | ((nxt == PREVIEW) && (state != PREVIEW));
      if (acct_ld) acct <= card_id;
      if (mode_ld)             mode_out <= menu_sel;
      else if (state == IDLE)  mode_out <= '0;
      balance_out <= session_state(state) ? cur_bal : '0;
    end
  end

  assign state_out = state;

  // Account store: one write port, addressed by the latched account id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal_q[i]   <= BAL_RST;
        tries_q[i] <= '0;
      end
      locked <= '0;
    end else begin
      if (wr_en) bal_q[acct] <= wr_data;
      if (tries_clr)      tries_q[acct] <= '0;
      else if (tries_inc) tries_q[acct] <= tries_cur + 1'b1;
      if (lock_set) locked[acct] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_atm_ctrl_multi.sv
// Bench for atm_ctrl_multi: vector table, hand sequences and a random run
// checked against an arithmetic account model.
module tb_atm_ctrl_multi;
  import atm_pkg::*;

  localparam int PV = 4;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        card_present = 1'b0;
  logic [1:0]  card_id = '0;
  logic [3:0]  pin_in = '0;
  logic [2:0]  menu_sel = '0;
  logic        confirm = 1'b0;
  logic        cancel = 1'b0;
  logic [7:0]  amount = '0;
  logic [15:0] balance_out;
  logic [3:0]  state_out;
  logic [2:0]  mode_out;
  logic        ok_pulse, fail_pulse, beep;
  logic [3:0]  locked;

  int n_cmp = 0;
  int n_bad = 0;
  int mbal [4];

  typedef struct {
    int op;
    int amt;
    int exp_ok;
    int exp_bal;
  } vec_t;
  vec_t tbl [10];

  atm_ctrl_multi #(.PREVIEW_CYC(PV), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .card_present (card_present),
    .card_id      (card_id),
    .pin_in       (pin_in),
    .menu_sel     (menu_sel),
    .confirm      (confirm),
    .cancel       (cancel),
    .amount       (amount),
    .balance_out  (balance_out),
    .state_out    (state_out),
    .mode_out     (mode_out),
    .ok_pulse     (ok_pulse),
    .fail_pulse   (fail_pulse),
    .beep         (beep),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Account rules straight from the transaction definitions.
  task automatic ref_txn(input int acct, input int op, input int amt, output bit ok);
    int b;
    b  = mbal[acct];
    ok = 1'b0;
    case (op)
      1: ok = 1'b1;
      2: if (b >= 20) begin ok = 1'b1; b -= 20; end
      3: if (amt != 0 && amt <= b) begin ok = 1'b1; b -= amt; end
      4: if (amt != 0 && b + amt <= 65535) begin ok = 1'b1; b += amt; end
      default: ok = 1'b0;
    endcase
    mbal[acct] = b;
  endtask

  task automatic login(input int id);
    card_id = 2'(id);
    card_present = 1'b1;
    step();
    check("pin_state", 32'(state_out), 32'(PIN));
    pin_in = 4'hA ^ 4'(id);
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    check("login_ok", 32'(ok_pulse), 1);
    check("login_menu", 32'(state_out), 32'(MENU));
  endtask

  task automatic leave();
    card_present = 1'b0;
    step();
    check("leave_exit", 32'(state_out), 32'(EXIT));
    step();
    check("leave_idle", 32'(state_out), 32'(IDLE));
  endtask

  // Select a menu entry from MENU and ride out the preview to the dispatched state.
  task automatic goto_mode(input int op);
    atm_state_e exp_st;
    case (op)
      1: exp_st = SHOW_BAL;
      2: exp_st = RAPID;
      3: exp_st = WITHDRAW;
      4: exp_st = DEPOSIT;
      default: exp_st = EXIT;
    endcase
    menu_sel = 3'(op);
    step();
    menu_sel = '0;
    check("preview_enter", 32'(state_out), 32'(PREVIEW));
    check("preview_beep", 32'(beep), 1);
    repeat (PV - 1) step();
    check("preview_hold", 32'(state_out), 32'(PREVIEW));
    check("mode_latched", 32'(mode_out), 32'(op));
    step();
    check("dispatch", 32'(state_out), 32'(exp_st));
  endtask

  task automatic do_txn(input int op, input int amt, output logic gok, output logic gfail,
                        output logic [15:0] gbal);
    goto_mode(op);
    if (op == 3 || op == 4) begin
      amount = 8'(amt);
      confirm = 1'b1;
    end
    step();
    confirm = 1'b0;
    gok = ok_pulse;
    gfail = fail_pulse;
    check("txn_back_menu", 32'(state_out), 32'(MENU));
    step();
    gbal = balance_out;
  endtask

  task automatic run_txn(input int acct, input int op, input int amt);
    logic gok, gfail;
    logic [15:0] gbal;
    bit eok;
    do_txn(op, amt, gok, gfail, gbal);
    ref_txn(acct, op, amt, eok);
    check("model_ok", 32'(gok), 32'(eok));
    check("model_fail", 32'(gfail), 32'(!eok));
    check("model_bal", 32'(gbal), 32'(mbal[acct]));
  endtask

  initial begin
    logic gok, gfail;
    logic [15:0] gbal;
    bit eok;
    int n;

    tbl[0] = '{1, 0,   1, 100};
    tbl[1] = '{3, 30,  1, 70};
    tbl[2] = '{3, 200, 0, 70};
    tbl[3] = '{2, 0,   1, 50};
    tbl[4] = '{3, 0,   0, 50};
    tbl[5] = '{4, 0,   0, 50};
    tbl[6] = '{4, 15,  1, 65};
    tbl[7] = '{3, 65,  1, 0};
    tbl[8] = '{2, 0,   0, 0};
    tbl[9] = '{4, 255, 1, 255};
    for (int i = 0; i < 4; i++) mbal[i] = 100;

    repeat (2) step();
    check("rst_state", 32'(state_out), 32'(IDLE));
    check("rst_bal", 32'(balance_out), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_pulses", 32'({ok_pulse, fail_pulse, beep}), 0);
    check("rst_mode", 32'(mode_out), 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Account 1: table-driven transactions.
    login(1);
    for (int i = 0; i < 10; i++) begin
      do_txn(tbl[i].op, tbl[i].amt, gok, gfail, gbal);
      ref_txn(1, tbl[i].op, tbl[i].amt, eok);
      check("tbl_ok", 32'(gok), 32'(tbl[i].exp_ok));
      check("tbl_fail", 32'(gfail), 32'(tbl[i].exp_ok == 0));
      check("tbl_bal", 32'(gbal), 32'(tbl[i].exp_bal));
    end
    goto_mode(5);
    card_present = 1'b0;
    step();
    check("exit_idle", 32'(state_out), 32'(IDLE));
    check("idle_bal_zero", 32'(balance_out), 0);

    // Account 2: three wrong PINs lock it; reinsertion is refused.
    card_id = 2'd2;
    card_present = 1'b1;
    step();
    pin_in = 4'h0;
    for (int t = 0; t < 3; t++) begin
      confirm = 1'b1;
      step();
      confirm = 1'b0;
      check("bad_pin_fail", 32'(fail_pulse), 1);
      check("bad_pin_ok", 32'(ok_pulse), 0);
      check("bad_pin_state", 32'(state_out), 32'(t == 2 ? EXIT : PIN));
      if (t < 2) step();
    end
    check("locked_flag", 32'(locked), 32'(4'b0100));
    card_present = 1'b0;
    step();
    card_present = 1'b1;
    step();
    check("locked_reinsert_fail", 32'(fail_pulse), 1);
    check("locked_reinsert_exit", 32'(state_out), 32'(EXIT));
    card_present = 1'b0;
    step();

    // Account 0: removal beats confirm in DEPOSIT, cancel beats confirm in WITHDRAW.
    login(0);
    goto_mode(4);
    amount = 8'd50;
    confirm = 1'b1;
    card_present = 1'b0;
    step();
    confirm = 1'b0;
    check("remove_exit", 32'(state_out), 32'(EXIT));
    check("remove_no_pulse", 32'({ok_pulse, fail_pulse}), 0);
    step();
    login(0);
    run_txn(0, 1, 0);
    goto_mode(3);
    amount = 8'd10;
    confirm = 1'b1;
    cancel = 1'b1;
    step();
    confirm = 1'b0;
    cancel = 1'b0;
    check("cancel_menu", 32'(state_out), 32'(MENU));
    check("cancel_no_pulse", 32'({ok_pulse, fail_pulse}), 0);
    run_txn(0, 1, 0);
    leave();

    // Inactivity in MENU: fail exactly TO cycles after entry.
    login(0);
    n = 0;
    for (int k = 1; k <= TO + 10; k++) begin
      step();
      if (fail_pulse) begin
        n = k;
        break;
      end
    end
    check("timeout_cycles", 32'(n), TO);
    check("timeout_exit", 32'(state_out), 32'(EXIT));
    card_present = 1'b0;
    step();

    // Random transactions on account 0 against the model.
    login(0);
    for (int r = 0; r < 40; r++) begin
      int op, amt;
      op = int'($urandom_range(1, 4));
      amt = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      run_txn(0, op, amt);
    end
    leave();

    // Account 3: drive the balance to the top of its range.
    login(3);
    for (int d = 0; d < 256; d++) run_txn(3, 4, 255);
    run_txn(3, 4, 20);
    do_txn(4, 255, gok, gfail, gbal);
    ref_txn(3, 4, 255, eok);
    check("ovf_fail", 32'(gfail), 1);
    check("ovf_bal", 32'(gbal), 65400);
    do_txn(4, 135, gok, gfail, gbal);
    ref_txn(3, 4, 135, eok);
    check("full_ok", 32'(gok), 1);
    check("full_bal", 32'(gbal), 65535);
    run_txn(3, 4, 1);

    // Reset mid-WITHDRAW.
    leave();
    login(0);
    goto_mode(3);
    amount = 8'd5;
    rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(state_out), 32'(IDLE));
    check("mid_rst_locked", 32'(locked), 0);
    check("mid_rst_bal", 32'(balance_out), 0);
    check("mid_rst_outs", 32'({mode_out, ok_pulse, fail_pulse, beep}), 0);
    card_present = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) mbal[i] = 100;
    login(2);
    run_txn(2, 1, 0);
    leave();
    login(3);
    run_txn(3, 1, 0);
    leave();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
